// File: rtl/seq_truth_table_unit.sv
// Registered N-input Boolean function unit: serially loaded truth table,
// one-cycle evaluation, and a sweep engine that streams the table and counts minterms.
module seq_truth_table_unit #(
    parameter  int N_IN = 4,
    localparam int TBL  = 1 << N_IN,
    localparam int CW   = N_IN + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] in_vec,
    input  logic            eval_en,
    output logic            y,
    input  logic            cfg_load,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            sweep_start,
    output logic            sweep_busy,
    output logic            sweep_valid,
    output logic [N_IN-1:0] sweep_idx,
    output logic            sweep_y,
    output logic            sweep_done,
    output logic [CW-1:0]   minterm_count,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    localparam logic [CW-1:0]   LAST_CNT = CW'(TBL - 1);
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

    state_t          state;
    logic [TBL-1:0]  active;
    logic [TBL-1:0]  shadow;
    logic [TBL-1:0]  shadow_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   acc;
    logic [N_IN-1:0] idx_inc;

    function automatic logic [CW-1:0] popcount(input logic [TBL-1:0] t);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < TBL; i++) c = c + CW'(t[i]);
        return c;
    endfunction

    // Shadow as it will look once the incoming bit is written; the commit
    // edge copies this so the last bit lands in the active table atomically.
    always_comb begin
        shadow_next = shadow;
        shadow_next[cnt[N_IN-1:0]] = cfg_bit;
    end

    assign idx_inc   = sweep_idx + N_IN'(1);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            active        <= '0;
            shadow        <= '0;
            cnt           <= '0;
            acc           <= '0;
            y             <= 1'b0;
            cfg_busy      <= 1'b0;
            cfg_done      <= 1'b0;
            sweep_busy    <= 1'b0;
            sweep_valid   <= 1'b0;
            sweep_idx     <= '0;
            sweep_y       <= 1'b0;
            sweep_done    <= 1'b0;
            minterm_count <= '0;
        end else begin
            cfg_done   <= 1'b0;
            sweep_done <= 1'b0;
            if (eval_en) y <= active[in_vec];

            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        state    <= LOAD;
                        cfg_busy <= 1'b1;
                        cnt      <= '0;
                        shadow   <= '0;
                    end else if (sweep_start) begin
                        state       <= SWEEP;
                        sweep_busy  <= 1'b1;
                        sweep_valid <= 1'b1;
                        sweep_idx   <= '0;
                        sweep_y     <= active[0];
                        acc         <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_load) begin
                        cnt    <= '0;
                        shadow <= '0;
                    end else if (cfg_valid) begin
                        shadow <= shadow_next;
                        cnt    <= cnt + CW'(1);
                        if (cnt == LAST_CNT) begin
                            active        <= shadow_next;
                            minterm_count <= popcount(shadow_next);
                            cfg_done      <= 1'b1;
                            cfg_busy      <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                SWEEP: begin
                    acc <= acc + CW'(sweep_y);
                    if (sweep_idx == LAST_IDX) begin
                        sweep_valid   <= 1'b0;
                        sweep_done    <= 1'b1;
                        sweep_busy    <= 1'b0;
                        minterm_count <= acc + CW'(sweep_y);
                        state         <= IDLE;
                    end else begin
                        sweep_idx <= idx_inc;
                        sweep_y   <= active[idx_inc];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
